// File: rtl/ir_rx_pkg.sv
// IR receiver shared types: coding modes, FSM states, segment classes.
// Timing defaults assume a 1 MHz clock and a 36 kHz carrier.
package ir_rx_pkg;

  localparam int unsigned ENV_TIMEOUT_DEF = 40;
  localparam int unsigned MIN_DEF         = 300;
  localparam int unsigned SHORT_MAX_DEF   = 1300;
  localparam int unsigned LONG_MAX_DEF    = 2300;
  localparam int unsigned IDLE_DEF        = 4000;

  typedef enum logic [1:0] {
    MODE_BIPHASE = 2'd0,
    MODE_PDIST   = 2'd1,
    MODE_PLEN    = 2'd2,
    MODE_RSV     = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    C_GLITCH,
    C_SHORT,
    C_LONG,
    C_OVER
  } seg_class_t;

  function automatic seg_class_t classify(
    input logic [15:0] len,
    input logic [15:0] lo,
    input logic [15:0] smax,
    input logic [15:0] lmax
  );
    seg_class_t c;
    if (len < lo)        c = C_GLITCH;
    else if (len < smax) c = C_SHORT;
    else if (len < lmax) c = C_LONG;
    else                 c = C_OVER;
    return c;
  endfunction

endpackage

// File: rtl/ir_rx_envelope.sv
// Carrier envelope detector: synchronizer, rising-edge detect and
// a quiet-time timeout that turns carrier bursts into a mark level.
module ir_rx_envelope
  import ir_rx_pkg::*;
#(
  parameter int unsigned P_ENV_TIMEOUT = ENV_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic env,
  output logic rise,
  output logic fall
);

  localparam logic [15:0] TMO = 16'(P_ENV_TIMEOUT);

  logic [2:0]  sync;
  logic [15:0] tmo_cnt;
  logic        edge_s;

  assign edge_s = sync[1] & ~sync[2];

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], din};
  end

  // Envelope rises on a carrier edge and falls after a quiet timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      env     <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      rise <= edge_s & ~env;
      fall <= 1'b0;
      if (edge_s) begin
        env     <= 1'b1;
        tmo_cnt <= TMO;
      end else if (tmo_cnt != 16'd0) begin
        tmo_cnt <= tmo_cnt - 16'd1;
        if (tmo_cnt == 16'd1) begin
          env  <= 1'b0;
          fall <= env;
        end
      end
    end
  end

endmodule

// File: rtl/ir_rx_decoder.sv
// IR frame decoder: classifies envelope segments and assembles
// bi-phase, pulse-distance or pulse-length frames into a word.
module ir_rx_decoder
  import ir_rx_pkg::*;
#(
  parameter int unsigned P_ENV_TIMEOUT = ENV_TIMEOUT_DEF,
  parameter int unsigned P_MIN         = MIN_DEF,
  parameter int unsigned P_SHORT_MAX   = SHORT_MAX_DEF,
  parameter int unsigned P_LONG_MAX    = LONG_MAX_DEF,
  parameter int unsigned P_IDLE        = IDLE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ir_din,
  input  logic [1:0]  i_mode_sel,
  input  logic [5:0]  i_bits_cnt,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [15:0] MIN_L  = 16'(P_MIN);
  localparam logic [15:0] SMAX_L = 16'(P_SHORT_MAX);
  localparam logic [15:0] LMAX_L = 16'(P_LONG_MAX);
  localparam logic [15:0] IDLE_L = 16'(P_IDLE);

  logic        env, rise, fall;
  logic [15:0] seg_cnt;
  state_t      state;
  mode_t       mode;
  logic [5:0]  nbits, idx;
  logic [31:0] sreg;
  logic        half, armed;
  seg_class_t  cls;
  logic        is_mark, seg_end, idle_hit, last;
  logic        dec, dbit, bad, half_n;

  ir_rx_envelope #(
    .P_ENV_TIMEOUT(P_ENV_TIMEOUT)
  ) u_env (
    .clk (i_clk),
    .rst (i_rst),
    .din (i_ir_din),
    .env (env),
    .rise(rise),
    .fall(fall)
  );

  // Saturating count of cycles since the last envelope transition
  always_ff @(posedge i_clk) begin
    if (i_rst)               seg_cnt <= '0;
    else if (rise || fall)   seg_cnt <= 16'd1;
    else if (seg_cnt != '1)  seg_cnt <= seg_cnt + 16'd1;
  end

  assign cls      = classify(seg_cnt, MIN_L, SMAX_L, LMAX_L);
  assign is_mark  = (state == S_MARK);
  assign seg_end  = (is_mark && fall) || (state == S_SPACE && rise);
  assign idle_hit = (state == S_SPACE) && !env && (seg_cnt >= IDLE_L);
  assign last     = (idx == nbits - 6'd1);

  // Per-segment bit decision; half marks a segment starting mid-bit
  always_comb begin
    dec    = 1'b0;
    dbit   = 1'b0;
    bad    = 1'b0;
    half_n = half;
    if (state == S_MARK || state == S_SPACE) begin
      if (mode == MODE_RSV) begin
        bad = 1'b1;
      end else if (idle_hit) begin
        if (mode == MODE_BIPHASE && half) dec = 1'b1;
        else                              bad = 1'b1;
      end else if (seg_end) begin
        if (cls == C_GLITCH || cls == C_OVER) begin
          bad = 1'b1;
        end else begin
          unique case (mode)
            MODE_BIPHASE: begin
              if (half) begin
                dec    = 1'b1;
                dbit   = is_mark;
                half_n = (cls == C_LONG);
              end else if (cls == C_LONG) begin
                bad = 1'b1;
              end else begin
                half_n = 1'b1;
              end
            end
            MODE_PDIST: begin
              if (is_mark) bad = (cls != C_SHORT);
              else begin
                dec  = 1'b1;
                dbit = (cls == C_LONG);
              end
            end
            MODE_PLEN: begin
              if (!is_mark) bad = (cls != C_SHORT);
              else begin
                dec  = 1'b1;
                dbit = (cls == C_LONG);
              end
            end
            MODE_RSV: bad = 1'b1;
          endcase
        end
      end
    end
  end

  // Frame FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      mode    <= MODE_BIPHASE;
      nbits   <= '0;
      idx     <= '0;
      sreg    <= '0;
      half    <= 1'b0;
      armed   <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!armed) begin
            armed <= !env && (seg_cnt >= IDLE_L);
          end else if (rise) begin
            state  <= S_MARK;
            mode   <= mode_t'(i_mode_sel);
            nbits  <= (i_bits_cnt == 6'd0 || i_bits_cnt > 6'd32)
                      ? 6'd32 : i_bits_cnt;
            idx    <= '0;
            sreg   <= '0;
            half   <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        S_MARK, S_SPACE: begin
          if (bad || (dec && idle_hit && !last)) begin
            state  <= S_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            armed  <= 1'b0;
          end else if (dec && last) begin
            state   <= S_DONE;
            o_valid <= 1'b1;
            o_data  <= sreg | ({31'b0, dbit} << idx[4:0]);
            o_busy  <= 1'b0;
            armed   <= 1'b0;
          end else begin
            if (dec) begin
              sreg[idx[4:0]] <= dbit;
              idx            <= idx + 6'd1;
            end
            half <= half_n;
            if (seg_end) state <= is_mark ? S_SPACE : S_MARK;
          end
        end
        S_DONE, S_ERR: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_rx_decoder.sv
// Bench for ir_rx_decoder: frames are synthesized as carrier bursts,
// expected words are queued at send time and matched on o_valid/o_err.
module tb_ir_rx_decoder;

  // Time base scaled by 1/4 against the default 1 MHz timing
  localparam int CAR  = 7;
  localparam int HALF = CAR * 32;
  localparam int GAP  = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir;
  logic [1:0]  mode_sel;
  logic [5:0]  bits_cnt;
  logic [31:0] o_data;
  logic        o_valid, o_err, o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [5:0]  bits;
    int          nwave;
    logic [31:0] word;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  exp_t        sb[$];
  vec_t        tv[7];
  logic [31:0] last_data;

  always #5 clk = ~clk;

  ir_rx_decoder #(
    .P_ENV_TIMEOUT(10),
    .P_MIN        (75),
    .P_SHORT_MAX  (325),
    .P_LONG_MAX   (575),
    .P_IDLE       (1000)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ir_din  (ir),
    .i_mode_sel(mode_sel),
    .i_bits_cnt(bits_cnt),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_err     (o_err),
    .o_busy    (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every output event must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (o_valid || o_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out valid=%0b err=%0b data=%h",
                 o_valid, o_err, o_data);
      end else begin
        e = sb.pop_front();
        chk("kind", {30'b0, o_valid, o_err}, {30'b0, !e.is_err, e.is_err});
        chk("data", o_data, e.data);
      end
    end
  end

  task automatic send_mark(input int d);
    for (int t = 0; t < d; t++) begin
      @(negedge clk);
      ir = ((t % CAR) < 3);
    end
  endtask

  task automatic send_space(input int d);
    for (int t = 0; t < d; t++) begin
      @(negedge clk);
      ir = 1'b0;
    end
  endtask

  // Build half-bit levels for a frame, merge runs, send up to lim runs
  task automatic frame(input logic [1:0] m, input logic [5:0] bits,
                       input int nw, input logic [31:0] w,
                       input int lim, input int gap);
    bit         hq[$];
    bit         lv;
    int         run;
    int         i;
    int         cnt;
    logic [1:0] wm;
    wm = (m == 2'd3) ? 2'd2 : m;
    mode_sel = m;
    bits_cnt = bits;
    for (int k = 0; k < nw; k++) begin
      case (wm)
        2'd0: begin
          hq.push_back(!w[k]);
          hq.push_back(w[k]);
        end
        2'd1: begin
          hq.push_back(1'b1);
          hq.push_back(1'b0);
          if (w[k]) hq.push_back(1'b0);
        end
        default: begin
          hq.push_back(1'b1);
          if (w[k]) hq.push_back(1'b1);
          hq.push_back(1'b0);
        end
      endcase
    end
    if (wm == 2'd1) hq.push_back(1'b1);
    i   = 0;
    cnt = 0;
    while (i < hq.size() && cnt < lim) begin
      lv  = hq[i];
      run = 0;
      while (i < hq.size() && hq[i] == lv) begin
        run++;
        i++;
      end
      if (lv) send_mark(run * HALF);
      else    send_space(run * HALF);
      if (cnt == 0) begin
        mode_sel = 2'($urandom);
        bits_cnt = 6'($urandom);
      end
      cnt++;
    end
    send_space(gap);
  endtask

  task automatic expect_ev(input logic is_err, input logic [31:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = is_err ? last_data : d;
    if (!is_err) last_data = d;
    sb.push_back(e);
  endtask

  initial begin
    rst      = 1'b1;
    ir       = 1'b0;
    mode_sel = 2'd0;
    bits_cnt = 6'd0;
    last_data = '0;

    tv[0] = '{2'd0, 6'd14, 14, 32'h0000_1F04, 1'b0, 32'h0000_1F04};
    tv[1] = '{2'd1, 6'd8,  8,  32'h0000_00A5, 1'b0, 32'h0000_00A5};
    tv[2] = '{2'd2, 6'd8,  8,  32'h0000_003C, 1'b0, 32'h0000_003C};
    tv[3] = '{2'd2, 6'd0,  32, 32'h8000_000D, 1'b0, 32'h8000_000D};
    tv[4] = '{2'd1, 6'd5,  5,  32'h0000_0015, 1'b0, 32'h0000_0015};
    tv[5] = '{2'd0, 6'd7,  7,  32'h0000_006A, 1'b0, 32'h0000_006A};
    tv[6] = '{2'd3, 6'd8,  2,  32'h0000_003C, 1'b1, 32'h0000_0000};

    repeat (3) @(negedge clk);
    chk("rst_data",  o_data, 32'h0);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_err",   {31'b0, o_err}, 32'h0);
    chk("rst_busy",  {31'b0, o_busy}, 32'h0);
    rst = 1'b0;
    send_space(GAP);

    for (int i = 0; i < 7; i++) begin
      expect_ev(tv[i].exp_err, tv[i].exp_data);
      frame(tv[i].mode, tv[i].bits, tv[i].nwave, tv[i].word, 1000, GAP);
      chk("pending", 32'(sb.size()), 32'h0);
    end

    // Idle after 6 of 14 bi-phase bits: error, data held
    expect_ev(1'b1, 32'h0);
    frame(2'd0, 6'd14, 6, 32'h0000_1F04, 1000, GAP);
    chk("idle_pending", 32'(sb.size()), 32'h0);

    // Reset in mid-frame, then a clean frame
    frame(2'd0, 6'd14, 14, 32'h0000_1F04, 6, 0);
    chk("mid_busy", {31'b0, o_busy}, 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_busy", {31'b0, o_busy}, 32'h0);
    chk("mrst_data", o_data, 32'h0);
    last_data = '0;
    rst = 1'b0;
    send_space(GAP);
    expect_ev(1'b0, 32'h0000_1F04);
    frame(2'd0, 6'd14, 14, 32'h0000_1F04, 1000, GAP);
    chk("rst_pending", 32'(sb.size()), 32'h0);

    // Short glitch mark opens a frame, then a clean frame
    mode_sel = 2'd0;
    bits_cnt = 6'd14;
    expect_ev(1'b1, 32'h0);
    send_mark(25);
    send_space(HALF);
    frame(2'd0, 6'd14, 4, 32'h0000_1F04, 1000, GAP);
    expect_ev(1'b0, 32'h0000_02A6);
    frame(2'd0, 6'd10, 10, 32'h0000_02A6, 1000, GAP);
    chk("glitch_pending", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
